// File: rtl/top_pkg.sv
`timescale 1ns/1ps
// Shared widths and active-high seven-segment patterns for the hex display driver.
// Segment bit order: bit0..bit6 = a..g, bit7 = dp.
package top_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 8;
  localparam int unsigned VALUE_W  = 2 * NIBBLE_W;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  localparam logic [SEG_W-1:0] SEG_0 = 8'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 8'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 8'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 8'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 8'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 8'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 8'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 8'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 8'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 8'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 8'h77;
  localparam logic [SEG_W-1:0] SEG_B = 8'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 8'h39;
  localparam logic [SEG_W-1:0] SEG_D = 8'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 8'h79;
  localparam logic [SEG_W-1:0] SEG_F = 8'h71;

endpackage : top_pkg

// File: rtl/hex_to_seven_seg.sv
`timescale 1ns/1ps
// Combinational nibble-to-segment decoder; the dp bit is never lit.
module hex_to_seven_seg
  import top_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_nibble,
  output logic [SEG_W-1:0]    o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg_c = SEG_0;
      4'h1: o_seg_c = SEG_1;
      4'h2: o_seg_c = SEG_2;
      4'h3: o_seg_c = SEG_3;
      4'h4: o_seg_c = SEG_4;
      4'h5: o_seg_c = SEG_5;
      4'h6: o_seg_c = SEG_6;
      4'h7: o_seg_c = SEG_7;
      4'h8: o_seg_c = SEG_8;
      4'h9: o_seg_c = SEG_9;
      4'hA: o_seg_c = SEG_A;
      4'hB: o_seg_c = SEG_B;
      4'hC: o_seg_c = SEG_C;
      4'hD: o_seg_c = SEG_D;
      4'hE: o_seg_c = SEG_E;
      4'hF: o_seg_c = SEG_F;
      default: o_seg_c = SEG_BLANK;
    endcase
  end

endmodule : hex_to_seven_seg

// File: rtl/top.sv
`timescale 1ns/1ps
// Dual-digit hex display driver: both nibbles of Value are decoded and
// registered together so the two digits always change on the same edge.
module top
  import top_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] Value,
  output logic [SEG_W-1:0]   SevenSegDig1,
  output logic [SEG_W-1:0]   SevenSegDig2
);

  logic [SEG_W-1:0] w_seg_dig1;
  logic [SEG_W-1:0] w_seg_dig2;
  logic [SEG_W-1:0] r_seg_dig1;
  logic [SEG_W-1:0] r_seg_dig2;

  hex_to_seven_seg u_dec_hi (
    .i_nibble (Value[VALUE_W-1:NIBBLE_W]),
    .o_seg_c  (w_seg_dig1)
  );

  hex_to_seven_seg u_dec_lo (
    .i_nibble (Value[NIBBLE_W-1:0]),
    .o_seg_c  (w_seg_dig2)
  );

  // Output registers blank the display asynchronously while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_dig1 <= SEG_BLANK;
      r_seg_dig2 <= SEG_BLANK;
    end else begin
      r_seg_dig1 <= w_seg_dig1;
      r_seg_dig2 <= w_seg_dig2;
    end
  end

  assign SevenSegDig1 = r_seg_dig1;
  assign SevenSegDig2 = r_seg_dig2;

endmodule : top

// File: tb/tb_top.sv
`timescale 1ns/1ps
// Self-checking bench for the dual-digit hex display driver.
module tb_top;

  typedef struct {
    logic [7:0] value;
    logic [7:0] exp_dig1;
    logic [7:0] exp_dig2;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] Value;
  logic [7:0] SevenSegDig1;
  logic [7:0] SevenSegDig2;

  int n_checks;
  int n_fail;

  logic [7:0] glyph [16];
  vec_t       vecs  [8];

  top dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Value        (Value),
    .SevenSegDig1 (SevenSegDig1),
    .SevenSegDig2 (SevenSegDig2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference display: glyph for the given hex digit, straight from the nibble map.
  function automatic logic [7:0] show(input logic [3:0] digit);
    return glyph[digit];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_pair(input string name, input logic [7:0] e1, input logic [7:0] e2);
    check({name, "_dig1"}, SevenSegDig1, e1);
    check({name, "_dig2"}, SevenSegDig2, e2);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] junk;
    n_checks = 0;
    n_fail   = 0;

    glyph[0]  = 8'h3F; glyph[1]  = 8'h06; glyph[2]  = 8'h5B; glyph[3]  = 8'h4F;
    glyph[4]  = 8'h66; glyph[5]  = 8'h6D; glyph[6]  = 8'h7D; glyph[7]  = 8'h07;
    glyph[8]  = 8'h7F; glyph[9]  = 8'h6F; glyph[10] = 8'h77; glyph[11] = 8'h7C;
    glyph[12] = 8'h39; glyph[13] = 8'h5E; glyph[14] = 8'h79; glyph[15] = 8'h71;

    vecs[0] = '{8'hC6, 8'h39, 8'h7D};
    vecs[1] = '{8'h00, 8'h3F, 8'h3F};
    vecs[2] = '{8'hFF, 8'h71, 8'h71};
    vecs[3] = '{8'h89, 8'h7F, 8'h6F};
    vecs[4] = '{8'hAB, 8'h77, 8'h7C};
    vecs[5] = '{8'hDE, 8'h5E, 8'h79};
    vecs[6] = '{8'h57, 8'h6D, 8'h07};
    vecs[7] = '{8'h34, 8'h4F, 8'h66};

    // Reset held with clock running: display stays blank.
    rst_n = 1'b0;
    Value = 8'hC6;
    repeat (3) @(posedge clk);
    #1 check_pair("reset_hold", 8'h00, 8'h00);

    // Release between edges: still blank until the first rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_pair("post_release", 8'h00, 8'h00);
    @(posedge clk);
    #1 check_pair("first_edge_C6", 8'h39, 8'h7D);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      Value = vecs[i].value;
      @(posedge clk);
      #1 check_pair($sformatf("vec%0d", i), vecs[i].exp_dig1, vecs[i].exp_dig2);
    end

    // Full sweep of all byte values.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      v = 8'(i);
      Value = v;
      @(posedge clk);
      #1;
      check_pair($sformatf("sweep_%02h", v), show(v[7:4]), show(v[3:0]));
      check($sformatf("sweep_dp_%02h", v), {SevenSegDig1[7], SevenSegDig2[7], 6'd0}, 8'h00);
    end

    // Input change between edges is invisible until the next edge.
    @(negedge clk);
    Value = 8'h12;
    @(posedge clk);
    #1 check_pair("hold_12", 8'h06, 8'h5B);
    #2 Value = 8'h34;
    #1 check_pair("no_comb_path", 8'h06, 8'h5B);
    @(posedge clk);
    #1 check_pair("update_34", 8'h4F, 8'h66);

    // Asynchronous reset mid-cycle, then reload on first edge after release.
    @(negedge clk);
    Value = 8'hAF;
    @(posedge clk);
    #1 check_pair("load_AF", 8'h77, 8'h71);
    #2 rst_n = 1'b0;
    #1 check_pair("async_clear", 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_pair("cleared_after_release", 8'h00, 8'h00);
    @(posedge clk);
    #1 check_pair("reload_AF", 8'h77, 8'h71);

    // Random values with glitches before the sampling edge.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      junk  = 8'($urandom);
      v     = 8'($urandom);
      Value = junk;
      #2 Value = v;
      @(posedge clk);
      #1 check_pair($sformatf("rand%0d_%02h", i, v), show(v[7:4]), show(v[3:0]));
      #1 Value = 8'($urandom);
      #1 check_pair($sformatf("rand%0d_stable", i), show(v[7:4]), show(v[3:0]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net: the stimulus above is bounded, but never let the run hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past 200000 ns");
    $fatal(1, "timeout");
  end

endmodule : tb_top
